trap_sequencer: RTL and testbench

- Sequences machine-mode trap entry and mret exit around the CSR register file.
- Samples pending interrupts and synchronous exceptions at instruction boundaries and picks one by fixed priority.
- Stalls and flushes the pipeline, pulses the CSR capture strobe (mepc/mcause/mtval), then redirects fetch to mtvec or mepc.
- Sits between the EX stage, the interrupt sources, the CSR array and the PC unit.

---
 rtl/trap_sequencer.sv | 111 +++++++++++
 tb/tb_trap_sequencer.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/trap_sequencer.sv
// trap_sequencer: machine-mode trap entry and mret exit sequencer (stall, flush, CSR capture, fetch redirect).
// Define TRAP_WFI_EN to add the cmd_wfi_ex input and a WFI sleep state.
module trap_sequencer #(
  parameter int          FLUSH_CYCLES = 2,
  parameter logic [29:0] RESET_VEC    = 30'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_stat_pc,
  input  logic        g_interrupt,
  input  logic        frc_cntr_val_leq,
  input  logic        soft_int,
  input  logic        csr_rmie,
  input  logic        csr_meie,
  input  logic        csr_mtie,
  input  logic        csr_msie,
  input  logic        illegal_ops_ex,
  input  logic        cmd_ebreak_ex,
  input  logic        cmd_ecall_ex,
  input  logic        cmd_mret_ex,
`ifdef TRAP_WFI_EN
  input  logic        cmd_wfi_ex,
`endif
  input  logic [29:0] pc_ex,
  input  logic [29:0] pc_next,
  input  logic [31:0] csr_mtvec,
  input  logic [29:0] csr_mepc,
  output logic        pipe_stall,
  output logic        pipe_flush,
  output logic        trap_take,
  output logic        trap_is_int,
  output logic [5:0]  trap_cause,
  output logic [29:0] trap_epc,
  output logic        mret_take,
  output logic        pc_redirect_valid,
  output logic [29:0] pc_redirect
);
  typedef enum logic [2:0] {
    IDLE, FLUSH, CAPTURE, REDIRECT, MRET
`ifdef TRAP_WFI_EN
    , WFI
`endif
  } state_t;
  state_t      state, state_d;
  logic [3:0]  cnt;
  logic        hold;
  logic        sync_ev, int_pend, accept, take_sync, take_int, take_mret;
  logic [5:0]  sync_cause, int_cause;
  logic [29:0] vec_off;
  assign sync_ev    = illegal_ops_ex | cmd_ebreak_ex | cmd_ecall_ex;
  assign sync_cause = illegal_ops_ex ? 6'd2 : cmd_ebreak_ex ? 6'd3 : 6'd11;
  assign int_pend   = (g_interrupt & csr_meie) | (soft_int & csr_msie) | (frc_cntr_val_leq & csr_mtie);
  assign int_cause  = (g_interrupt & csr_meie) ? 6'd11 : (soft_int & csr_msie) ? 6'd3 : 6'd7;
  // hold masks the first IDLE cycle after a trap redirect
  assign accept     = state == IDLE && cpu_stat_pc && !hold;
  assign take_sync  = accept && sync_ev;
  assign take_mret  = accept && !sync_ev && cmd_mret_ex;
`ifdef TRAP_WFI_EN
  logic take_wfi;
  assign take_wfi = accept && !sync_ev && !cmd_mret_ex && !(csr_rmie && int_pend) && cmd_wfi_ex;
  assign take_int = (accept && !sync_ev && !cmd_mret_ex && csr_rmie && int_pend) ||
                    (state == WFI && csr_rmie && int_pend);
`else
  assign take_int = accept && !sync_ev && !cmd_mret_ex && csr_rmie && int_pend;
`endif
  always_comb begin
    state_d = state;
    case (state)
`ifdef TRAP_WFI_EN
      IDLE:     state_d = (take_sync || take_int) ? FLUSH : take_mret ? MRET : take_wfi ? WFI : IDLE;
      WFI:      state_d = take_int ? FLUSH : int_pend ? IDLE : WFI;
`else
      IDLE:     state_d = (take_sync || take_int) ? FLUSH : take_mret ? MRET : IDLE;
`endif
      FLUSH:    state_d = cnt == 4'(FLUSH_CYCLES - 1) ? CAPTURE : FLUSH;
      CAPTURE:  state_d = REDIRECT;
      default:  state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      cnt         <= 4'd0;
      hold        <= 1'b0;
      trap_cause  <= 6'd0;
      trap_is_int <= 1'b0;
      trap_epc    <= 30'd0;
    end else begin
      state <= state_d;
      cnt   <= state == FLUSH ? cnt + 4'd1 : 4'd0;
      hold  <= state == REDIRECT;
      if (take_sync) begin
        trap_cause  <= sync_cause;
        trap_is_int <= 1'b0;
        trap_epc    <= pc_ex;
      end else if (take_int) begin
        trap_cause  <= int_cause;
        trap_is_int <= 1'b1;
        trap_epc    <= pc_next;
      end
    end
  end
  assign vec_off           = (csr_mtvec[1:0] == 2'b01 && trap_is_int) ? 30'(trap_cause) : 30'd0;
  assign pipe_stall        = state != IDLE;
  assign pipe_flush        = state == FLUSH || state == MRET;
  assign trap_take         = state == CAPTURE;
  assign mret_take         = state == MRET;
  assign pc_redirect_valid = state == REDIRECT || state == MRET;
  assign pc_redirect       = state == REDIRECT ? csr_mtvec[31:2] + vec_off :
                             state == MRET     ? csr_mepc : RESET_VEC;
endmodule

// File: tb/tb_trap_sequencer.sv
// tb_trap_sequencer: directed and randomized checks of trap_sequencer against a priority-table reference model.
module tb_trap_sequencer;
  localparam int          F  = 2;
  localparam logic [29:0] RV = 30'h0000_0200;
  localparam int SYNC_CAUSE [3] = '{2, 3, 11};
  localparam int INT_CAUSE  [3] = '{11, 3, 7};
  logic        clk = 1'b0;
  logic        rst;
  logic        stat, gi, ti, si, rmie, meie, mtie, msie, ill, ebk, ecl, mrt;
  logic [29:0] pc_ex, pc_next, mepc;
  logic [31:0] mtvec;
  logic        pipe_stall, pipe_flush, trap_take, trap_is_int, mret_take, pc_redirect_valid;
  logic [5:0]  trap_cause;
  logic [29:0] trap_epc, pc_redirect;
  int          checks = 0, failures = 0;
  logic [31:0] obs_cause, obs_int, obs_epc, obs_redir, obs_mret;

  trap_sequencer #(.FLUSH_CYCLES(F), .RESET_VEC(RV)) dut (
    .clk(clk), .rst(rst), .cpu_stat_pc(stat), .g_interrupt(gi), .frc_cntr_val_leq(ti),
    .soft_int(si), .csr_rmie(rmie), .csr_meie(meie), .csr_mtie(mtie), .csr_msie(msie),
    .illegal_ops_ex(ill), .cmd_ebreak_ex(ebk), .cmd_ecall_ex(ecl), .cmd_mret_ex(mrt),
    .pc_ex(pc_ex), .pc_next(pc_next), .csr_mtvec(mtvec), .csr_mepc(mepc),
    .pipe_stall(pipe_stall), .pipe_flush(pipe_flush), .trap_take(trap_take),
    .trap_is_int(trap_is_int), .trap_cause(trap_cause), .trap_epc(trap_epc),
    .mret_take(mret_take), .pc_redirect_valid(pc_redirect_valid), .pc_redirect(pc_redirect)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear();
    {stat, gi, ti, si, rmie, meie, mtie, msie, ill, ebk, ecl, mrt} = '0;
    pc_ex = '0; pc_next = '0; mepc = '0; mtvec = '0;
  endtask

  task automatic scramble();
    stat = 1'($urandom); gi = 1'($urandom); ti = 1'($urandom); si = 1'($urandom);
    rmie = 1'($urandom); meie = 1'($urandom); mtie = 1'($urandom); msie = 1'($urandom);
    ill = 1'($urandom); ebk = 1'($urandom); ecl = 1'($urandom); mrt = 1'($urandom);
    pc_ex = 30'($urandom); pc_next = 30'($urandom);
  endtask

  task automatic expect_out(input string tag, input logic s, input logic f, input logic t,
                            input logic m, input logic v);
    chk({tag, "_stall"}, 32'(pipe_stall), 32'(s));
    chk({tag, "_flush"}, 32'(pipe_flush), 32'(f));
    chk({tag, "_take"},  32'(trap_take), 32'(t));
    chk({tag, "_mret"},  32'(mret_take), 32'(m));
    chk({tag, "_rv"},    32'(pc_redirect_valid), 32'(v));
  endtask

  task automatic check_idle(input string tag);
    expect_out(tag, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    chk({tag, "_redir"}, 32'(pc_redirect), 32'(RV));
  endtask

  // Reference: first active source in each priority table wins
  task automatic predict(output int kind, output logic [5:0] c, output logic ii, output logic [29:0] e);
    logic sv [3];
    logic iv [3];
    sv = '{ill, ebk, ecl};
    iv = '{gi && meie, si && msie, ti && mtie};
    kind = 0; c = '0; ii = 1'b0; e = '0;
    if (!stat) return;
    for (int i = 0; i < 3; i++)
      if (sv[i] && kind == 0) begin kind = 1; c = 6'(SYNC_CAUSE[i]); e = pc_ex; end
    if (kind != 0) return;
    if (mrt) begin kind = 2; return; end
    if (!rmie) return;
    for (int i = 0; i < 3; i++)
      if (iv[i] && kind == 0) begin kind = 1; ii = 1'b1; c = 6'(INT_CAUSE[i]); e = pc_next; end
  endtask

  task automatic run_txn();
    int          kind;
    logic [5:0]  c;
    logic        ii;
    logic [29:0] e, tgt;
    predict(kind, c, ii, e);
    tgt = mtvec[31:2] + ((mtvec[1:0] == 2'b01 && ii) ? 30'(c) : 30'd0);
    obs_cause = '1; obs_int = '1; obs_epc = '1; obs_redir = '1; obs_mret = '1;
    tick();
    if (kind == 1) begin
      for (int k = 1; k <= F + 2; k++) begin
        expect_out("trap", 1'b1, k <= F, k == F + 1, 1'b0, k == F + 2);
        chk("trap_cause", 32'(trap_cause), 32'(c));
        chk("trap_is_int", 32'(trap_is_int), 32'(ii));
        chk("trap_epc", 32'(trap_epc), 32'(e));
        if (k == F + 1) begin obs_cause = 32'(trap_cause); obs_int = 32'(trap_is_int); obs_epc = 32'(trap_epc); end
        if (k == F + 2) begin
          chk("trap_target", 32'(pc_redirect), 32'(tgt));
          obs_redir = 32'(pc_redirect);
        end
        scramble();
        tick();
      end
      check_idle("trap_end");
      scramble();
      stat = 1'b1; ill = 1'b1;
      tick();
      check_idle("trap_hold");
    end else if (kind == 2) begin
      expect_out("mret", 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      chk("mret_target", 32'(pc_redirect), 32'(mepc));
      obs_redir = 32'(pc_redirect);
      obs_mret = 32'(mret_take && pc_redirect_valid);
      scramble();
      stat = 1'b0;
      tick();
      check_idle("mret_end");
    end else begin
      check_idle("none");
    end
    stat = 1'b0;
  endtask

  initial begin
    clear();
    rst = 1'b1;
    tick();
    tick();
    check_idle("reset");
    chk("reset_cause", 32'(trap_cause), 32'd0);
    chk("reset_epc", 32'(trap_epc), 32'd0);
    @(negedge clk) rst = 1'b0;

    clear(); mtvec = 32'h100; rmie = 1; meie = 1; gi = 1; pc_next = 30'h10; pc_ex = 30'h3; stat = 1;
    run_txn();
    chk("d1_cause", obs_cause, 32'd11);
    chk("d1_int", obs_int, 32'd1);
    chk("d1_epc", obs_epc, 32'h10);
    chk("d1_redir", obs_redir, 32'h40);

    clear(); mtvec = 32'h101; rmie = 1; mtie = 1; ti = 1; stat = 1;
    run_txn();
    chk("d2_cause", obs_cause, 32'd7);
    chk("d2_redir", obs_redir, 32'h47);

    clear(); mtvec = 32'h101; ill = 1; gi = 1; meie = 1; pc_ex = 30'h55; pc_next = 30'h99; stat = 1;
    run_txn();
    chk("d3_cause", obs_cause, 32'd2);
    chk("d3_int", obs_int, 32'd0);
    chk("d3_epc", obs_epc, 32'h55);
    chk("d3_redir", obs_redir, 32'h40);

    clear(); mtvec = 32'h200; ecl = 1; stat = 1;
    run_txn();
    chk("d4_cause", obs_cause, 32'd11);
    chk("d4_int", obs_int, 32'd0);
    chk("d4_redir", obs_redir, 32'h80);

    clear(); mrt = 1; mepc = 30'h123; gi = 1; meie = 1; rmie = 1; stat = 1;
    run_txn();
    chk("d5_mret", obs_mret, 32'd1);
    chk("d5_redir", obs_redir, 32'h123);

    clear(); mtvec = 32'hFFFF_FFF1; rmie = 1; meie = 1; gi = 1; stat = 1;
    run_txn();
    chk("d6_wrap", obs_redir, 32'h7);

    clear(); mtvec = 32'h100; rmie = 1; meie = 1; gi = 1; stat = 1;
    tick();
    chk("rst_pre_flush", 32'(pipe_flush), 32'd1);
    stat = 0; gi = 0;
    #2 rst = 1'b1;
    #1;
    check_idle("rst_mid");
    chk("rst_mid_cause", 32'(trap_cause), 32'd0);
    chk("rst_mid_epc", 32'(trap_epc), 32'd0);
    @(negedge clk) rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      tick();
      chk("rst_no_take", 32'(trap_take), 32'd0);
      chk("rst_no_stall", 32'(pipe_stall), 32'd0);
    end

    for (int n = 0; n < 200; n++) begin
      clear();
      mtvec = $urandom;
      mtvec[1:0] = $urandom_range(0, 1) ? 2'b01 : 2'b00;
      mepc = 30'($urandom);
      pc_ex = 30'($urandom); pc_next = 30'($urandom);
      stat = $urandom_range(0, 7) != 0;
      ill = $urandom_range(0, 7) == 0; ebk = $urandom_range(0, 7) == 0;
      ecl = $urandom_range(0, 7) == 0; mrt = $urandom_range(0, 5) == 0;
      gi = 1'($urandom); si = 1'($urandom); ti = 1'($urandom);
      meie = 1'($urandom); msie = 1'($urandom); mtie = 1'($urandom);
      rmie = $urandom_range(0, 3) != 0;
      run_txn();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
